// File: rtl/light_sensor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | light_sensor_pkg                                                            |
// | Shared types and constants for the light sensor front end.                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package light_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

  localparam logic DAY   = 1'b0;
  localparam logic NIGHT = 1'b1;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/light_adc_spi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | light_adc_spi_rx                                                            |
// | SPI mode-0 receiver: CS/SCLK sequencing and MSB-first capture of one word.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module light_adc_spi_rx
  import light_sensor_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int ADC_BITS  = 10,
  parameter int LEAD_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_miso,
  output logic                o_sclk,
  output logic                o_cs_n,
  output logic                o_busy,
  output logic                o_ready,
  output logic                o_finish,
  output logic [ADC_BITS-1:0] o_word
);

  localparam int c_n_bits = LEAD_BITS + ADC_BITS;
  localparam int c_div_w  = width_for(CLK_DIV - 1);
  localparam int c_bit_w  = width_for(c_n_bits - 1);

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_n_bits - 1);
  localparam logic [c_bit_w-1:0] c_lead     = c_bit_w'(LEAD_BITS);

  spi_state_t          r_state;
  logic [c_div_w-1:0]  r_div;
  logic [c_bit_w-1:0]  r_bit;
  logic [ADC_BITS-1:0] r_shift;
  logic                r_sclk;
  logic                r_cs_n;
  logic                r_busy;
  logic                w_div_end;

  assign w_div_end = (r_div == c_div_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a start directly so back-to-back frames keep CS high one cycle.
        ST_IDLE, ST_DONE: begin
          r_div  <= '0;
          r_bit  <= '0;
          r_sclk <= 1'b0;
          if (i_start) begin
            r_state <= ST_SETUP;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Capture during the first high cycle of each SCLK period.
          if (r_sclk && (r_div == '0) && (r_bit >= c_lead)) begin
            r_shift <= {r_shift[ADC_BITS-2:0], i_miso};
          end
          if (w_div_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              if (r_bit == c_bit_last) begin
                r_state <= ST_HOLD;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= ST_DONE;
            r_cs_n  <= 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sclk   = r_sclk;
  assign o_cs_n   = r_cs_n;
  assign o_busy   = r_busy;
  assign o_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign o_finish = (r_state == ST_HOLD) && w_div_end;
  assign o_word   = r_shift;

endmodule
`default_nettype wire

// File: rtl/light_sensor_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | light_sensor_frontend                                                       |
// | Periodic ADC sampling with hysteresis/dwell filtering into a day/night flag.|
// | Optional 4-sample averaging when LIGHT_SENSOR_AVG_EN is defined.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module light_sensor_frontend
  import light_sensor_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int ADC_BITS      = 10,
  parameter int LEAD_BITS     = 3,
  parameter int DARK_TH       = 200,
  parameter int BRIGHT_TH     = 300,
  parameter int DWELL         = 3
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                adc_miso,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic                light_sensor,
  output logic [ADC_BITS-1:0] sample_data,
  output logic                sample_valid,
  output logic                busy
);

  localparam int c_per_w = width_for(SAMPLE_PERIOD - 1);
  localparam int c_str_w = width_for(DWELL);

  localparam logic [c_per_w-1:0]  c_per_last  = c_per_w'(SAMPLE_PERIOD - 1);
  localparam logic [c_str_w-1:0]  c_dwell     = c_str_w'(DWELL);
  localparam logic [ADC_BITS-1:0] c_dark_th   = ADC_BITS'(DARK_TH);
  localparam logic [ADC_BITS-1:0] c_bright_th = ADC_BITS'(BRIGHT_TH);

  logic [c_per_w-1:0]  r_period;
  logic                r_pending;
  logic                w_request;
  logic                w_start;
  logic                w_rx_ready;
  logic                w_finish;
  logic [ADC_BITS-1:0] w_raw;
  logic [ADC_BITS-1:0] w_cmp;

  assign w_request = (r_period == c_per_last);
  assign w_start   = w_request | r_pending;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_period  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_period <= w_request ? '0 : r_period + 1'b1;
      // At most one start is remembered while a conversion is in flight.
      if (w_start && w_rx_ready) begin
        r_pending <= 1'b0;
      end else if (w_request) begin
        r_pending <= 1'b1;
      end
    end
  end

  light_adc_spi_rx #(
    .CLK_DIV   (CLK_DIV),
    .ADC_BITS  (ADC_BITS),
    .LEAD_BITS (LEAD_BITS)
  ) u_spi_rx (
    .clk      (clk_in),
    .rst_n    (reset_n),
    .i_start  (w_start),
    .i_miso   (adc_miso),
    .o_sclk   (adc_sclk),
    .o_cs_n   (adc_cs_n),
    .o_busy   (busy),
    .o_ready  (w_rx_ready),
    .o_finish (w_finish),
    .o_word   (w_raw)
  );

`ifdef LIGHT_SENSOR_AVG_EN
  // Three previous samples; the fourth window entry is the incoming one.
  logic [ADC_BITS-1:0] r_win0;
  logic [ADC_BITS-1:0] r_win1;
  logic [ADC_BITS-1:0] r_win2;
  logic                r_win_full;
  logic [ADC_BITS+1:0] w_sum;

  always_comb begin
    if (r_win_full) begin
      w_sum = {2'b00, w_raw} + {2'b00, r_win0} + {2'b00, r_win1} + {2'b00, r_win2};
    end else begin
      w_sum = {w_raw, 2'b00};
    end
  end

  assign w_cmp = w_sum[ADC_BITS+1:2];

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_win0     <= '0;
      r_win1     <= '0;
      r_win2     <= '0;
      r_win_full <= 1'b0;
    end else if (w_finish) begin
      r_win0     <= w_raw;
      r_win1     <= r_win_full ? r_win0 : w_raw;
      r_win2     <= r_win_full ? r_win1 : w_raw;
      r_win_full <= 1'b1;
    end
  end
`else
  assign w_cmp = w_raw;
`endif

  logic               r_light;
  logic [c_str_w-1:0] r_streak;
  logic [ADC_BITS-1:0] r_data;
  logic               r_valid;
  logic               w_dark;
  logic               w_bright;
  logic               w_qualify;
  logic [c_str_w-1:0] w_streak_inc;

  // Threshold-equal values are neutral in both directions.
  assign w_dark       = (w_cmp < c_dark_th);
  assign w_bright     = (w_cmp > c_bright_th);
  assign w_qualify    = (r_light == DAY) ? w_dark : w_bright;
  assign w_streak_inc = r_streak + 1'b1;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_light  <= DAY;
      r_streak <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_finish;
      if (w_finish) begin
        r_data <= w_cmp;
        if (!w_qualify) begin
          r_streak <= '0;
        end else if (w_streak_inc >= c_dwell) begin
          r_streak <= '0;
          r_light  <= (r_light == DAY) ? NIGHT : DAY;
        end else begin
          r_streak <= w_streak_inc;
        end
      end
    end
  end

  assign light_sensor = r_light;
  assign sample_data  = r_data;
  assign sample_valid = r_valid;

endmodule
`default_nettype wire
